fetch_decode_queue: RTL and testbench
=====================================

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 Parameter XLEN, default 64: address/PC width.
REQ-002 Parameter INSTRUCTION_LENGTH, default XLEN/2: instruction word width.
REQ-003 Parameter DEPTH, default 4: queue entries; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 fetch_valid  input  1  fetch stage presents a valid PC/instruction pair.
REQ-007 fetch_PC  input  XLEN  PC of the presented instruction.
REQ-008 fetch_instruction  input  INSTRUCTION_LENGTH  instruction word at fetch_PC.
REQ-009 fetch_ready  output  1  queue can accept a push this cycle.
REQ-010 flush  input  1  discard all queued entries (branch/jump redirect).
REQ-011 decode_valid  output  1  head entry present for decode.
REQ-012 decode_ready  input  1  decode consumes the head entry this cycle.
REQ-013 decode_PC  output  XLEN  PC of the head entry.
REQ-014 decode_instruction  output  INSTRUCTION_LENGTH  instruction of the head entry.
REQ-015 count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Function
REQ-016 The block SHALL be a FIFO of DEPTH {PC, instruction} entries, with head pointer, tail pointer and occupancy counter.
REQ-017 Push occurs when fetch_valid && fetch_ready && !flush; the entry is written at tail, tail advances, and count increments.
REQ-018 Pop occurs when decode_valid && decode_ready && !flush; head advances and count decrements.
REQ-019 On a simultaneous push and pop, count SHALL be unchanged, and both pointers SHALL advance.
REQ-020 fetch_ready SHALL be combinational: 1 iff count < DEPTH; when full, a same-cycle pop SHALL NOT enable a push.
REQ-021 decode_valid SHALL be combinational: 1 iff count != 0; there is no input-to-output bypass.
REQ-022 Latency: an entry pushed at edge N SHALL appear at the decode outputs after edge N (1 cycle) if the queue was empty.
REQ-023 decode_PC/decode_instruction SHALL reflect the head entry when decode_valid=1, and SHALL be driven to 0 when the queue is empty.
REQ-024 Pointers SHALL wrap modulo DEPTH, and entries SHALL be popped in exact push order.
REQ-025 flush=1 at an edge SHALL set count, head and tail to 0 and SHALL ignore any same-cycle push or pop.
REQ-026 Flush SHALL NOT gate fetch_ready or decode_valid combinationally; they follow count.
REQ-027 fetch_valid with fetch_ready=0 SHALL leave state unchanged, and fetch holds its PC.
REQ-028 decode_ready with decode_valid=0 SHALL leave state unchanged, and count SHALL NOT underflow.

Reset
REQ-029 rst=1 at an edge SHALL set count=0, head=0 and tail=0, with priority over flush, push and pop.
REQ-030 After reset: decode_valid=0, fetch_ready=1, decode_PC=0, decode_instruction=0, count=0.
REQ-031 Storage contents SHALL NOT require reset.
REQ-032 Reset asserted mid-operation SHALL discard all entries at that edge.

Verification
REQ-033 Push PC=0x10/instr=0x00000013 into an empty queue, decode_ready=0 -> the next cycle gives decode_valid=1, decode_PC=0x10, count=1.
REQ-034 Push 4 entries (PC 0..3) with decode_ready=0 -> fetch_ready=0 and count=4; a 5th fetch_valid is dropped; pops return PCs 0,1,2,3 in order.
REQ-035 Queue at count=2, push and pop in the same cycle -> count stays 2 and the head advances by one entry.
REQ-036 Queue at count=3, flush=1 with fetch_valid=1 and decode_ready=1 -> the next cycle gives count=0, decode_valid=0, and the pushed entry is not stored.
REQ-037 Stream 10 entries with random decode_ready -> output order equals input order across pointer wrap, with no loss or duplication.
REQ-038 Queue at count=2, rst=1 for one cycle -> count=0, decode_valid=0, decode_PC=0, fetch_ready=1.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of {PC, instruction}
// pairs between the fetch and decode stages, with flush for redirects.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   fetch_valid         - fetch presents a PC/instruction pair
//   fetch_PC            - PC of the presented instruction (XLEN bits)
//   fetch_instruction   - instruction word (INSTRUCTION_LENGTH bits)
//   fetch_ready         - queue can accept a push this cycle (count < DEPTH)
//   flush               - discard all queued entries at the next edge
//   decode_valid        - head entry present (count != 0)
//   decode_ready        - decode consumes the head entry this cycle
//   decode_PC           - PC of head entry, 0 when empty
//   decode_instruction  - instruction of head entry, 0 when empty
//   count               - number of occupied entries, 0..DEPTH
module fetch_decode_queue #(
   parameter int XLEN               = 64,
   parameter int INSTRUCTION_LENGTH = XLEN / 2,
   parameter int DEPTH              = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fetch_valid,
   input  logic [XLEN-1:0]               fetch_PC,
   input  logic [INSTRUCTION_LENGTH-1:0] fetch_instruction,
   output logic                          fetch_ready,
   input  logic                          flush,
   output logic                          decode_valid,
   input  logic                          decode_ready,
   output logic [XLEN-1:0]               decode_PC,
   output logic [INSTRUCTION_LENGTH-1:0] decode_instruction,
   output logic [$clog2(DEPTH):0]        count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [XLEN-1:0]               pc;
      logic [INSTRUCTION_LENGTH-1:0] instr;
   } entry_t;

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic push;
   logic pop;

   // Handshakes follow the registered count only; flush acts at the edge.
   // When full, fetch_ready is 0 even if decode pops in the same cycle.
   assign fetch_ready  = (count_q < CNT_W'(DEPTH));
   assign decode_valid = (count_q != '0);
   assign count        = count_q;

   always_comb begin
      decode_PC          = '0;
      decode_instruction = '0;
      if (decode_valid) begin
         decode_PC          = mem_q[head_q].pc;
         decode_instruction = mem_q[head_q].instr;
      end
   end

   always_comb begin
      push    = fetch_valid && fetch_ready && !flush;
      pop     = decode_valid && decode_ready && !flush;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      mem_d   = mem_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[tail_q] = '{pc: fetch_PC, instr: fetch_instruction};
            // DEPTH is a power of two, so pointers wrap by overflow.
            tail_d = tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is never reset; count gates every read of it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed stimulus with a scoreboard queue
// checked by a negedge monitor, plus hand-computed directed checks.
module tb_fetch_decode_queue;

   localparam int XLEN  = 64;
   localparam int ILEN  = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             fetch_valid;
   logic [XLEN-1:0]  fetch_PC;
   logic [ILEN-1:0]  fetch_instruction;
   logic             fetch_ready;
   logic             flush;
   logic             decode_valid;
   logic             decode_ready;
   logic [XLEN-1:0]  decode_PC;
   logic [ILEN-1:0]  decode_instruction;
   logic [2:0]       count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [XLEN-1:0] exp_pc [$];
   logic [ILEN-1:0] exp_in [$];

   fetch_decode_queue #(
      .XLEN(XLEN), .INSTRUCTION_LENGTH(ILEN), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .fetch_valid(fetch_valid), .fetch_PC(fetch_PC),
      .fetch_instruction(fetch_instruction), .fetch_ready(fetch_ready),
      .flush(flush),
      .decode_valid(decode_valid), .decode_ready(decode_ready),
      .decode_PC(decode_PC), .decode_instruction(decode_instruction),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: reference queue model, compared at negedge each cycle.
   always @(negedge clk) begin
      int  cnt;
      logic do_push, do_pop;
      cnt = exp_pc.size();
      if (!rst) begin
         chk("mon_count", 64'(count), 64'(cnt));
         chk("mon_fetch_ready", 64'(fetch_ready), 64'(cnt < DEPTH));
         chk("mon_decode_valid", 64'(decode_valid), 64'(cnt != 0));
         if (cnt != 0) begin
            chk("mon_head_pc", decode_PC, exp_pc[0]);
            chk("mon_head_instr", 64'(decode_instruction), 64'(exp_in[0]));
         end else begin
            chk("mon_empty_pc", decode_PC, 64'h0);
            chk("mon_empty_instr", 64'(decode_instruction), 64'h0);
         end
      end
      if (rst || flush) begin
         exp_pc.delete();
         exp_in.delete();
      end else begin
         do_push = fetch_valid && (cnt < DEPTH);
         do_pop  = decode_ready && (cnt != 0);
         if (do_pop) begin
            void'(exp_pc.pop_front());
            void'(exp_in.pop_front());
         end
         if (do_push) begin
            exp_pc.push_back(fetch_PC);
            exp_in.push_back(fetch_instruction);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] in);
      fetch_valid = 1'b1;
      fetch_PC = pc;
      fetch_instruction = in;
      step();
      fetch_valid = 1'b0;
   endtask

   initial begin
      int sent;
      int budget;
      rst = 1'b1;
      fetch_valid = 1'b0;
      fetch_PC = '0;
      fetch_instruction = '0;
      flush = 1'b0;
      decode_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_valid", 64'(decode_valid), 64'h0);
      chk("rst_ready", 64'(fetch_ready), 64'h1);
      chk("rst_count", 64'(count), 64'h0);
      chk("rst_pc", decode_PC, 64'h0);
      chk("rst_instr", 64'(decode_instruction), 64'h0);

      // single push, one-cycle latency
      push1(64'h10, 32'h0000_0013);
      chk("lat_valid", 64'(decode_valid), 64'h1);
      chk("lat_pc", decode_PC, 64'h10);
      chk("lat_instr", 64'(decode_instruction), 64'h13);
      chk("lat_count", 64'(count), 64'h1);
      decode_ready = 1'b1;
      step();
      decode_ready = 1'b0;
      chk("lat_drain", 64'(count), 64'h0);

      // fill to full; 5th push dropped even with same-cycle pop
      for (int i = 0; i < 4; i++) push1(64'(i), 32'hA0 + 32'(i));
      chk("full_ready", 64'(fetch_ready), 64'h0);
      chk("full_count", 64'(count), 64'h4);
      chk("full_head", decode_PC, 64'h0);
      fetch_valid = 1'b1;
      fetch_PC = 64'h4;
      fetch_instruction = 32'hA4;
      decode_ready = 1'b1;
      step();
      fetch_valid = 1'b0;
      chk("full_drop_count", 64'(count), 64'h3);
      for (int i = 1; i < 4; i++) begin
         chk("full_order", decode_PC, 64'(i));
         step();
      end
      decode_ready = 1'b0;
      chk("full_empty", 64'(count), 64'h0);

      // simultaneous push and pop at count=2
      push1(64'h100, 32'h1);
      push1(64'h104, 32'h2);
      fetch_valid = 1'b1;
      fetch_PC = 64'h108;
      fetch_instruction = 32'h3;
      decode_ready = 1'b1;
      step();
      fetch_valid = 1'b0;
      decode_ready = 1'b0;
      chk("pp_count", 64'(count), 64'h2);
      chk("pp_head", decode_PC, 64'h104);

      // flush at count=3 beats push and pop
      push1(64'h10C, 32'h4);
      chk("fl_pre_count", 64'(count), 64'h3);
      flush = 1'b1;
      fetch_valid = 1'b1;
      fetch_PC = 64'h200;
      fetch_instruction = 32'h5;
      decode_ready = 1'b1;
      step();
      flush = 1'b0;
      fetch_valid = 1'b0;
      decode_ready = 1'b0;
      chk("fl_count", 64'(count), 64'h0);
      chk("fl_valid", 64'(decode_valid), 64'h0);
      chk("fl_pc", decode_PC, 64'h0);
      push1(64'h300, 32'h6);
      chk("fl_after_pc", decode_PC, 64'h300);
      chk("fl_after_count", 64'(count), 64'h1);
      decode_ready = 1'b1;
      step();
      decode_ready = 1'b0;

      // stream 10 entries with random decode_ready across wrap
      sent = 0;
      budget = 0;
      while (sent < 10 && budget < 200) begin
         fetch_valid = 1'b1;
         fetch_PC = 64'h1000 + 64'(4 * sent);
         fetch_instruction = 32'hC0DE_0000 + 32'(sent);
         decode_ready = 1'($urandom_range(0, 1));
         #1;
         if (fetch_ready) sent++;
         step();
         budget++;
      end
      fetch_valid = 1'b0;
      chk("stream_sent", 64'(sent), 64'd10);
      decode_ready = 1'b1;
      budget = 0;
      while (decode_valid && budget < 20) begin
         step();
         budget++;
      end
      decode_ready = 1'b0;
      chk("stream_drained", 64'(count), 64'h0);

      // reset mid-operation at count=2
      push1(64'h500, 32'h7);
      push1(64'h504, 32'h8);
      chk("mr_pre_count", 64'(count), 64'h2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_count", 64'(count), 64'h0);
      chk("mr_valid", 64'(decode_valid), 64'h0);
      chk("mr_pc", decode_PC, 64'h0);
      chk("mr_ready", 64'(fetch_ready), 64'h1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
